// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions: memory-port request types, screen geometry and
// the sprite-draw state encoding.
package chip8_pkg;

  localparam logic MEM_TYPE_VRAM = 1'b0;
  localparam logic MEM_TYPE_RAM  = 1'b1;

  localparam int SCREEN_W       = 64;
  localparam int SCREEN_H       = 32;
  localparam int VRAM_ROW_BYTES = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_SPR,
    ST_WT_SPR,
    ST_RD_L,
    ST_WT_L,
    ST_WR_L,
    ST_WT_WL,
    ST_RD_R,
    ST_WT_R,
    ST_WR_R,
    ST_WT_WR,
    ST_NEXT,
    ST_DONE
  } draw_state_e;

endpackage

// File: rtl/chip8_sprite_shifter.sv
// Splits one sprite byte across two VRAM bytes for a pixel offset sh (0..7).
// Purely combinational so it can be reused by the hires draw path.
module chip8_sprite_shifter (
  input  logic [7:0] s_i,
  input  logic [2:0] sh_i,
  output logic [7:0] l_o,
  output logic [7:0] r_o,
  output logic       r_present_o
);

  logic [15:0] wide;

  // Upper byte is S>>sh, lower byte holds the bits shifted out to the right.
  assign wide        = {s_i, 8'h00} >> sh_i;
  assign l_o         = wide[15:8];
  assign r_o         = wide[7:0];
  assign r_present_o = |sh_i;

endmodule

// File: rtl/chip8_sprite_draw.sv
// DXYN sprite-draw engine: reads sprite rows from RAM, XORs them into VRAM
// through a single-outstanding valid/ready + rvalid port, and reports collision.
module chip8_sprite_draw
  import chip8_pkg::*;
#(
  parameter bit CLIP     = 1'b1,
  parameter int MAX_ROWS = 15
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic [7:0]  x_in,
  input  logic [7:0]  y_in,
  input  logic [3:0]  n_in,
  input  logic [11:0] i_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        vf_out,
  output logic [15:0] mem_addr_out,
  output logic        mem_we_out,
  output logic        mem_valid_out,
  output logic [7:0]  mem_data_out,
  output logic        mem_type_out,
  input  logic        mem_ready_in,
  input  logic        mem_rvalid_in,
  input  logic [7:0]  mem_rdata_in
);

  localparam logic [3:0] MAX_N = 4'(MAX_ROWS);

  draw_state_e state_q;
  logic [5:0]  xo_q;
  logic [4:0]  yo_q;
  logic [3:0]  n_q;
  logic [11:0] i_q;
  logic [3:0]  r_q;
  logic [7:0]  s_q;
  logic        coll_q;
  logic        busy_q, done_q, vf_q;
  logic        valid_q, we_q, type_q;
  logic [15:0] addr_q;
  logic [7:0]  data_q;

  logic [2:0]  col, sh;
  logic [4:0]  row_cur;
  logic [4:0]  r_nx;
  logic [5:0]  nx_sum;
  logic        row_last;
  logic [11:0] spr_addr_nx;
  logic [3:0]  n_eff;
  logic [7:0]  l_part, r_part;
  logic        r_present, right_ok;
  logic        unused_bits;

  assign col         = xo_q[5:3];
  assign sh          = xo_q[2:0];
  assign row_cur     = yo_q + {1'b0, r_q};
  assign r_nx        = {1'b0, r_q} + 5'd1;
  assign nx_sum      = {1'b0, yo_q} + {1'b0, r_nx};
  // Draw ends after the last row, or earlier when the next row falls off the bottom.
  assign row_last    = (r_nx == {1'b0, n_q}) || (CLIP && (nx_sum > 6'd31));
  assign spr_addr_nx = i_q + {8'h00, r_nx[3:0]};
  assign n_eff       = (n_in > MAX_N) ? MAX_N : n_in;
  assign right_ok    = r_present && (!CLIP || (col != 3'd7));
  assign unused_bits = ^{x_in[7:6], y_in[7:5]};

  chip8_sprite_shifter u_shifter (
    .s_i         (s_q),
    .sh_i        (sh),
    .l_o         (l_part),
    .r_o         (r_part),
    .r_present_o (r_present)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      xo_q    <= '0;
      yo_q    <= '0;
      n_q     <= '0;
      i_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      coll_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vf_q    <= 1'b0;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      type_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            xo_q   <= x_in[5:0];
            yo_q   <= y_in[4:0];
            n_q    <= n_eff;
            i_q    <= i_in;
            r_q    <= '0;
            coll_q <= 1'b0;
            vf_q   <= 1'b0;
            if (n_eff == 4'd0) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              busy_q  <= 1'b1;
              valid_q <= 1'b1;
              we_q    <= 1'b0;
              type_q  <= MEM_TYPE_RAM;
              addr_q  <= {4'h0, i_in};
              data_q  <= '0;
              state_q <= ST_RD_SPR;
            end
          end
        end
        ST_RD_SPR, ST_RD_L, ST_WR_L, ST_RD_R, ST_WR_R: begin
          // Each request state is followed in the enum by its wait state.
          if (mem_ready_in) begin
            valid_q <= 1'b0;
            state_q <= draw_state_e'(state_q + 4'd1);
          end
        end
        ST_WT_SPR: begin
          if (mem_rvalid_in) begin
            s_q     <= mem_rdata_in;
            valid_q <= 1'b1;
            we_q    <= 1'b0;
            type_q  <= MEM_TYPE_VRAM;
            addr_q  <= {8'h00, row_cur, col};
            data_q  <= '0;
            state_q <= ST_RD_L;
          end
        end
        ST_WT_L: begin
          if (mem_rvalid_in) begin
            coll_q  <= coll_q | (|(mem_rdata_in & l_part));
            valid_q <= 1'b1;
            we_q    <= 1'b1;
            data_q  <= mem_rdata_in ^ l_part;
            state_q <= ST_WR_L;
          end
        end
        ST_WT_WL: begin
          if (mem_rvalid_in) begin
            if (right_ok) begin
              valid_q <= 1'b1;
              we_q    <= 1'b0;
              addr_q  <= {8'h00, row_cur, col + 3'd1};
              data_q  <= '0;
              state_q <= ST_RD_R;
            end else begin
              state_q <= ST_NEXT;
            end
          end
        end
        ST_WT_R: begin
          if (mem_rvalid_in) begin
            coll_q  <= coll_q | (|(mem_rdata_in & r_part));
            valid_q <= 1'b1;
            we_q    <= 1'b1;
            data_q  <= mem_rdata_in ^ r_part;
            state_q <= ST_WR_R;
          end
        end
        ST_WT_WR: begin
          if (mem_rvalid_in) state_q <= ST_NEXT;
        end
        ST_NEXT: begin
          if (row_last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            vf_q    <= coll_q;
            state_q <= ST_DONE;
          end else begin
            r_q     <= r_nx[3:0];
            valid_q <= 1'b1;
            we_q    <= 1'b0;
            type_q  <= MEM_TYPE_RAM;
            addr_q  <= {4'h0, spr_addr_nx};
            data_q  <= '0;
            state_q <= ST_RD_SPR;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign vf_out        = vf_q;
  assign mem_addr_out  = addr_q;
  assign mem_we_out    = we_q;
  assign mem_valid_out = valid_q;
  assign mem_data_out  = data_q;
  assign mem_type_out  = type_q;

endmodule

// File: tb/tb_chip8_sprite_draw.sv
// Directed bench for chip8_sprite_draw: clipped and wrapping instances share a
// RAM/VRAM responder model with configurable backpressure and response delay.
module tb_chip8_sprite_draw;

  typedef struct packed {
    logic        we;
    logic        typ;
    logic [15:0] addr;
    logic [7:0]  data;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  x = '0, y = '0;
  logic [3:0]  n = '0;
  logic [11:0] iaddr = '0;
  logic        ready = 1'b1, rvalid = 1'b0;
  logic [7:0]  rdata = '0;
  logic        sel = 1'b0;

  logic        c_busy, c_done, c_vf, c_we, c_valid, c_type;
  logic [15:0] c_addr;
  logic [7:0]  c_data;
  logic        w_busy, w_done, w_vf, w_we, w_valid, w_type;
  logic [15:0] w_addr;
  logic [7:0]  w_data;

  logic        m_busy, m_done, m_vf, m_we, m_valid, m_type;
  logic [15:0] m_addr;
  logic [7:0]  m_data;
  logic        start_c, start_w, ready_c, ready_w, rvalid_c, rvalid_w;

  assign start_c  = start & ~sel;
  assign start_w  = start & sel;
  assign ready_c  = ready & ~sel;
  assign ready_w  = ready & sel;
  assign rvalid_c = rvalid & ~sel;
  assign rvalid_w = rvalid & sel;
  assign m_busy   = sel ? w_busy  : c_busy;
  assign m_done   = sel ? w_done  : c_done;
  assign m_vf     = sel ? w_vf    : c_vf;
  assign m_we     = sel ? w_we    : c_we;
  assign m_valid  = sel ? w_valid : c_valid;
  assign m_type   = sel ? w_type  : c_type;
  assign m_addr   = sel ? w_addr  : c_addr;
  assign m_data   = sel ? w_data  : c_data;

  chip8_sprite_draw #(.CLIP(1'b1), .MAX_ROWS(15)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start_c),
    .x_in(x), .y_in(y), .n_in(n), .i_in(iaddr),
    .busy_out(c_busy), .done_out(c_done), .vf_out(c_vf),
    .mem_addr_out(c_addr), .mem_we_out(c_we), .mem_valid_out(c_valid),
    .mem_data_out(c_data), .mem_type_out(c_type),
    .mem_ready_in(ready_c), .mem_rvalid_in(rvalid_c), .mem_rdata_in(rdata)
  );

  chip8_sprite_draw #(.CLIP(1'b0), .MAX_ROWS(15)) dut_wrap (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start_w),
    .x_in(x), .y_in(y), .n_in(n), .i_in(iaddr),
    .busy_out(w_busy), .done_out(w_done), .vf_out(w_vf),
    .mem_addr_out(w_addr), .mem_we_out(w_we), .mem_valid_out(w_valid),
    .mem_data_out(w_data), .mem_type_out(w_type),
    .mem_ready_in(ready_w), .mem_rvalid_in(rvalid_w), .mem_rdata_in(rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] ram  [4096];
  logic [7:0] vram [256];
  req_t       log_q[$];

  int   bp_wait = 0, rv_delay = 0;
  int   stab_err = 0, ovl_err = 0, stall_cyc = 0;
  int   wait_cnt = 0, cnt = 0;
  logic pend = 1'b0, prev_v = 1'b0;
  logic [7:0] pdata = '0;
  req_t prev_req, cur_req;

  // Responder: decides ready/rvalid on the falling edge for the next rising edge.
  always @(negedge clk) begin
    cur_req = '{we: m_we, typ: m_type, addr: m_addr, data: m_data};
    if (!rst_n) begin
      pend = 1'b0; rvalid = 1'b0; ready = 1'b1; wait_cnt = 0; prev_v = 1'b0;
    end else begin
      if (pend && m_valid) ovl_err++;
      if (prev_v && m_valid && (cur_req !== prev_req)) stab_err++;
      rvalid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin rvalid = 1'b1; rdata = pdata; pend = 1'b0; end
        else cnt--;
      end
      if (m_valid && wait_cnt < bp_wait) begin
        ready = 1'b0; wait_cnt++; stall_cyc++;
      end else ready = 1'b1;
      if (m_valid && ready) begin
        log_q.push_back(cur_req);
        if (m_type) pdata = ram[m_addr[11:0]];
        else if (m_we) begin vram[m_addr[7:0]] = m_data; pdata = m_data; end
        else pdata = vram[m_addr[7:0]];
        pend = 1'b1; cnt = rv_delay; wait_cnt = 0; prev_v = 1'b0;
      end else begin
        prev_v = m_valid; prev_req = cur_req;
      end
    end
  end

  task automatic clear_vram();
    for (int k = 0; k < 256; k++) vram[k] = 8'h00;
  endtask

  task automatic run_draw(input logic [7:0] xv, input logic [7:0] yv, input logic [3:0] nv,
                          input logic [11:0] iv, output logic vf, output int cyc);
    logic got;
    got = 1'b0; cyc = 0; vf = 1'b0;
    log_q.delete();
    @(negedge clk);
    x = xv; y = yv; n = nv; iaddr = iv; start = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (m_done) begin got = 1'b1; vf = m_vf; break; end
    end
    checks++;
    if (!got) begin failures++; $display("FAIL draw_timeout: done=0 required done=1"); end
  endtask

  task automatic test_reset();
    checks++;
    if ({m_busy, m_done, m_vf, m_valid, m_we, m_type} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 000000", {m_busy, m_done, m_vf, m_valid, m_we, m_type});
    end
    checks++;
    if ({m_addr, m_data} !== 24'h0) begin
      failures++; $display("FAIL reset_bus: got %h required 000000", {m_addr, m_data});
    end
  endtask

  task automatic test_basic();
    logic vf; int cyc;
    sel = 1'b0; clear_vram(); ram[12'h200] = 8'hF0;
    run_draw(8'd0, 8'd0, 4'd1, 12'h200, vf, cyc);
    checks++;
    if (log_q.size() != 3) begin failures++; $display("FAIL basic_reqs: got %0d required 3", log_q.size()); end
    else begin
      checks++;
      if ({log_q[0].we, log_q[0].typ, log_q[0].addr} !== {2'b01, 16'h0200}) begin
        failures++; $display("FAIL basic_req0: got %h required 1_0200", {log_q[0].we, log_q[0].typ, log_q[0].addr});
      end
      checks++;
      if ({log_q[1].we, log_q[1].typ, log_q[1].addr} !== {2'b00, 16'h0000}) begin
        failures++; $display("FAIL basic_req1: got %h required 0_0000", {log_q[1].we, log_q[1].typ, log_q[1].addr});
      end
      checks++;
      if (log_q[2] !== '{we: 1'b1, typ: 1'b0, addr: 16'h0000, data: 8'hF0}) begin
        failures++; $display("FAIL basic_req2: got %h required 2_0000_f0", log_q[2]);
      end
    end
    checks++;
    if (vf !== 1'b0) begin failures++; $display("FAIL basic_vf: got %b required 0", vf); end
    checks++;
    if (vram[0] !== 8'hF0) begin failures++; $display("FAIL basic_vram: got %h required f0", vram[0]); end
    checks++;
    if (cyc != 8) begin failures++; $display("FAIL basic_latency: got %0d required 8", cyc); end
  endtask

  task automatic test_toggle();
    logic vf; int cyc;
    run_draw(8'd0, 8'd0, 4'd1, 12'h200, vf, cyc);
    checks++;
    if (vf !== 1'b1) begin failures++; $display("FAIL toggle_vf1: got %b required 1", vf); end
    checks++;
    if (vram[0] !== 8'h00) begin failures++; $display("FAIL toggle_vram1: got %h required 00", vram[0]); end
    repeat (3) @(negedge clk);
    checks++;
    if (m_vf !== 1'b1) begin failures++; $display("FAIL vf_hold: got %b required 1", m_vf); end
    run_draw(8'd0, 8'd0, 4'd1, 12'h200, vf, cyc);
    checks++;
    if (vf !== 1'b0) begin failures++; $display("FAIL toggle_vf2: got %b required 0", vf); end
    checks++;
    if (vram[0] !== 8'hF0) begin failures++; $display("FAIL toggle_vram2: got %h required f0", vram[0]); end
  endtask

  task automatic test_right_edge();
    logic vf; int cyc;
    sel = 1'b0; clear_vram(); ram[12'h300] = 8'hFF;
    run_draw(8'd60, 8'd1, 4'd1, 12'h300, vf, cyc);
    checks++;
    if ({vram[8'h0F], vram[8'h08]} !== 16'h0F00) begin
      failures++; $display("FAIL clip_edge_vram: got %h required 0f00", {vram[8'h0F], vram[8'h08]});
    end
    checks++;
    if (log_q.size() != 3) begin failures++; $display("FAIL clip_edge_reqs: got %0d required 3", log_q.size()); end
    sel = 1'b1; clear_vram(); vram[8'h08] = 8'h10;
    run_draw(8'd60, 8'd1, 4'd1, 12'h300, vf, cyc);
    checks++;
    if ({vram[8'h0F], vram[8'h08]} !== 16'h0FE0) begin
      failures++; $display("FAIL wrap_edge_vram: got %h required 0fe0", {vram[8'h0F], vram[8'h08]});
    end
    checks++;
    if (log_q.size() != 5) begin failures++; $display("FAIL wrap_edge_reqs: got %0d required 5", log_q.size()); end
    checks++;
    if (vf !== 1'b1) begin failures++; $display("FAIL wrap_edge_vf: got %b required 1", vf); end
    sel = 1'b0;
  endtask

  task automatic test_bottom_clip();
    logic vf; int cyc; int nspr;
    sel = 1'b0; clear_vram();
    ram[12'h400] = 8'h81; ram[12'h401] = 8'h42; ram[12'h402] = 8'h24; ram[12'h403] = 8'h18;
    run_draw(8'd70, 8'd30, 4'd4, 12'h400, vf, cyc);
    nspr = 0;
    foreach (log_q[k]) if (log_q[k].typ) nspr++;
    checks++;
    if (nspr != 2) begin failures++; $display("FAIL bottom_spr_reads: got %0d required 2", nspr); end
    checks++;
    if (log_q.size() != 10) begin failures++; $display("FAIL bottom_reqs: got %0d required 10", log_q.size()); end
    checks++;
    if ({vram[8'hF0], vram[8'hF1], vram[8'hF8], vram[8'hF9]} !== 32'h02040108) begin
      failures++;
      $display("FAIL bottom_vram: got %h required 02040108", {vram[8'hF0], vram[8'hF1], vram[8'hF8], vram[8'hF9]});
    end
    checks++;
    if ({vram[8'h00], vram[8'h01]} !== 16'h0000) begin
      failures++; $display("FAIL bottom_nowrap: got %h required 0000", {vram[8'h00], vram[8'h01]});
    end
  endtask

  task automatic test_zero_rows();
    logic vf; int cyc;
    sel = 1'b0;
    run_draw(8'd5, 8'd5, 4'd0, 12'h200, vf, cyc);
    checks++;
    if (cyc != 1) begin failures++; $display("FAIL zero_latency: got %0d required 1", cyc); end
    checks++;
    if (log_q.size() != 0) begin failures++; $display("FAIL zero_reqs: got %0d required 0", log_q.size()); end
    checks++;
    if (vf !== 1'b0) begin failures++; $display("FAIL zero_vf: got %b required 0", vf); end
    @(negedge clk);
    checks++;
    if (m_done !== 1'b0) begin failures++; $display("FAIL zero_done_pulse: got %b required 0", m_done); end
  endtask

  task automatic test_back_to_back();
    int dones;
    sel = 1'b0; clear_vram(); log_q.delete(); dones = 0;
    @(negedge clk);
    x = 8'd0; y = 8'd0; n = 4'd1; iaddr = 12'h200; start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      start = (k == 2 || k == 5);
      n = (k < 6) ? 4'd0 : 4'd1;
      if (m_done) dones++;
    end
    start = 1'b0;
    checks++;
    if (dones != 1) begin failures++; $display("FAIL b2b_dones: got %0d required 1", dones); end
    checks++;
    if (log_q.size() != 3 || vram[0] !== 8'hF0) begin
      failures++; $display("FAIL b2b_effect: got reqs=%0d vram=%h required reqs=3 vram=f0", log_q.size(), vram[0]);
    end
  endtask

  task automatic test_backpressure();
    logic vf; int cyc; int dones;
    sel = 1'b0; clear_vram(); ram[12'h500] = 8'hAA;
    bp_wait = 5; rv_delay = 3; stab_err = 0; ovl_err = 0; stall_cyc = 0;
    run_draw(8'd3, 8'd2, 4'd1, 12'h500, vf, cyc);
    checks++;
    if ({vram[8'h10], vram[8'h11]} !== 16'h1540) begin
      failures++; $display("FAIL bp_vram: got %h required 1540", {vram[8'h10], vram[8'h11]});
    end
    checks++;
    if (stab_err != 0) begin failures++; $display("FAIL bp_stable: got %0d changes required 0", stab_err); end
    checks++;
    if (ovl_err != 0) begin failures++; $display("FAIL bp_outstanding: got %0d overlaps required 0", ovl_err); end
    checks++;
    if (stall_cyc != 25) begin failures++; $display("FAIL bp_stalls: got %0d required 25", stall_cyc); end
    // Abandon a second draw part way through its first row.
    log_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_busy, m_done, m_valid, m_we, m_type, m_addr, m_data} !== 29'h0) begin
      failures++;
      $display("FAIL async_reset: got %h required 0", {m_busy, m_done, m_valid, m_we, m_type, m_addr, m_data});
    end
    dones = 0;
    repeat (3) begin @(negedge clk); if (m_done) dones++; end
    rst_n = 1'b1;
    bp_wait = 0; rv_delay = 0;
    repeat (40) begin @(negedge clk); if (m_done) dones++; end
    checks++;
    if (dones != 0) begin failures++; $display("FAIL reset_no_done: got %0d required 0", dones); end
  endtask

  initial begin
    for (int k = 0; k < 4096; k++) ram[k] = 8'h00;
    clear_vram();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_toggle();
    test_right_edge();
    test_bottom_clip();
    test_zero_rows();
    test_back_to_back();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
